// File: rtl/control_unit_pkg.sv
// Shared types and constants for the control unit: ALU modes, writeback source,
// sequencer states and the base-ISA opcode values it decodes.
package control_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_EQ,
        ALU_PASS_B
    } alu_mode_t;

    typedef enum logic [1:0] {
        DEST_NONE    = 2'd0,
        DEST_ALU     = 2'd1,
        DEST_BUS     = 2'd2,
        DEST_NEXT_PC = 2'd3
    } dest_reg_from_t;

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        EXECUTE   = 2'd1,
        WRITEBACK = 2'd2
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // f3 to ALU mode for OP/OP-IMM; alt picks SUB on 000 and SRA on 101.
    function automatic alu_mode_t op_mode(input logic [2:0] f3, input logic alt);
        alu_mode_t m;
        case (f3)
            3'b000:  m = alt ? ALU_SUB : ALU_ADD;
            3'b001:  m = ALU_SLL;
            3'b010:  m = ALU_SLT;
            3'b011:  m = ALU_SLTU;
            3'b100:  m = ALU_XOR;
            3'b101:  m = alt ? ALU_SRA : ALU_SRL;
            3'b110:  m = ALU_OR;
            default: m = ALU_AND;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/control_unit_alu.sv
// Combinational 32-bit ALU; shifts use b[4:0], compares return 0 or 1.
module alu
    import control_unit_pkg::*;
(
    input  alu_mode_t   mode,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = '0;
        case (mode)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << b[4:0];
            ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   y = {31'b0, a < b};
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> b[4:0];
            ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_EQ:     y = {31'b0, a == b};
            ALU_PASS_B: y = b;
            default:    y = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction decoder, operand muxing and FETCH/EXECUTE/WRITEBACK sequencer.
// Handshake: stall=1 freezes the sequencer; strobes stay valid for the held state.
module control_unit
    import control_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] ir,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic [31:0] pc,
    output logic [4:0]  rd_sel,
    output logic [4:0]  rs1_sel,
    output logic [4:0]  rs2_sel,
    output logic [6:0]  opcode,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [31:0] imm,
    output logic [31:0] len,
    output logic [31:0] alu_out,
    output logic        branch_taken,
    output logic        alu_in_a,
    output logic        alu_in_b,
    output logic [1:0]  dest_reg_from,
    output logic        pc_load,
    output logic        dbus_re,
    output logic        dbus_we,
    output logic        load_ir,
    output logic        en_iaddr,
    output logic        en_pc_counter,
    output logic        write_back_stage,
    output logic        rd_we,
    output state_t      state
);

    state_t         state_next;
    alu_mode_t      mode;
    dest_reg_from_t dest;
    logic           dec_re, dec_we, dec_pc_load, branching, jalr;
    logic [31:0]    alu_y;

    assign rd_sel  = ir[11:7];
    assign rs1_sel = ir[19:15];
    assign rs2_sel = ir[24:20];
    assign opcode  = ir[6:0];
    assign f3      = ir[14:12];
    assign f7      = ir[31:25];
    assign len     = 32'd4;

    always_comb begin
        imm = '0;
        case (opcode)
            OPC_LUI, OPC_AUIPC:           imm = {ir[31:12], 12'b0};
            OPC_JAL:                      imm = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: imm = {{20{ir[31]}}, ir[31:20]};
            OPC_STORE:                    imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH:                   imm = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            default:                      imm = '0;
        endcase
    end

    always_comb begin
        alu_in_a    = 1'b0;
        alu_in_b    = 1'b0;
        mode        = ALU_ADD;
        dest        = DEST_NONE;
        dec_re      = 1'b0;
        dec_we      = 1'b0;
        dec_pc_load = 1'b0;
        branching   = 1'b0;
        jalr        = 1'b0;
        case (opcode)
            OPC_LUI: begin
                alu_in_b = 1'b1;
                mode     = ALU_PASS_B;
                dest     = DEST_ALU;
            end
            OPC_AUIPC: begin
                alu_in_a = 1'b1;
                alu_in_b = 1'b1;
                dest     = DEST_ALU;
            end
            OPC_JAL: begin
                alu_in_a    = 1'b1;
                alu_in_b    = 1'b1;
                dest        = DEST_NEXT_PC;
                dec_pc_load = 1'b1;
            end
            OPC_JALR: begin
                alu_in_b    = 1'b1;
                dest        = DEST_NEXT_PC;
                dec_pc_load = 1'b1;
                jalr        = 1'b1;
            end
            OPC_BRANCH: begin
                // f3=01x has no branch meaning and falls through as a NOP.
                if (f3[2:1] != 2'b01) begin
                    branching = 1'b1;
                    mode      = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_EQ;
                end
            end
            OPC_LOAD: begin
                alu_in_b = 1'b1;
                dest     = DEST_BUS;
                dec_re   = 1'b1;
            end
            OPC_STORE: begin
                alu_in_b = 1'b1;
                dec_we   = 1'b1;
            end
            OPC_OP_IMM: begin
                alu_in_b = 1'b1;
                mode     = op_mode(f3, (f3 == 3'b101) && ir[30]);
                dest     = DEST_ALU;
            end
            OPC_OP: begin
                mode = op_mode(f3, ir[30]);
                dest = DEST_ALU;
            end
            default: ;
        endcase
    end

    alu u_alu (
        .mode (mode),
        .a    (alu_in_a ? pc : rs1_val),
        .b    (alu_in_b ? imm : rs2_val),
        .y    (alu_y)
    );

    assign alu_out       = {alu_y[31:1], alu_y[0] & ~jalr};
    assign branch_taken  = branching & ((alu_out != 32'd0) ^ f3[0]);
    assign dest_reg_from = dest;

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!stall) begin
            case (state)
                FETCH:     state_next = EXECUTE;
                EXECUTE:   state_next = WRITEBACK;
                WRITEBACK: state_next = FETCH;
                default:   state_next = FETCH;
            endcase
        end
    end

    // Reset forces every strobe low combinationally, not just after the edge.
    always_comb begin
        load_ir          = 1'b0;
        en_iaddr         = 1'b0;
        en_pc_counter    = 1'b0;
        write_back_stage = 1'b0;
        dbus_re          = 1'b0;
        dbus_we          = 1'b0;
        pc_load          = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    load_ir  = 1'b1;
                    en_iaddr = 1'b1;
                end
                EXECUTE: begin
                    dbus_re = dec_re;
                    dbus_we = dec_we;
                end
                WRITEBACK: begin
                    write_back_stage = 1'b1;
                    en_pc_counter    = 1'b1;
                    pc_load          = dec_pc_load;
                end
                default: ;
            endcase
        end
    end

    assign rd_we = (dest_reg_from != 2'd0) & write_back_stage;

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomized checks of control_unit against an ISA-level model.
module tb_control_unit;
    import control_unit_pkg::*;

    logic        clk, rst, stall;
    logic [31:0] ir, rs1_val, rs2_val, pc;
    logic [4:0]  rd_sel, rs1_sel, rs2_sel;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm, len, alu_out;
    logic        branch_taken, alu_in_a, alu_in_b;
    logic [1:0]  dest_reg_from;
    logic        pc_load, dbus_re, dbus_we, load_ir, en_iaddr, en_pc_counter;
    logic        write_back_stage, rd_we;
    state_t      state;

    int n_cmp = 0;
    int n_err = 0;
    int ph    = 0;
    logic [31:0] exp_q[$];

    control_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .ir(ir), .rs1_val(rs1_val),
        .rs2_val(rs2_val), .pc(pc), .rd_sel(rd_sel), .rs1_sel(rs1_sel),
        .rs2_sel(rs2_sel), .opcode(opcode), .f3(f3), .f7(f7), .imm(imm),
        .len(len), .alu_out(alu_out), .branch_taken(branch_taken),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .dest_reg_from(dest_reg_from),
        .pc_load(pc_load), .dbus_re(dbus_re), .dbus_we(dbus_we),
        .load_ir(load_ir), .en_iaddr(en_iaddr), .en_pc_counter(en_pc_counter),
        .write_back_stage(write_back_stage), .rd_we(rd_we), .state(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; the model sequencer advances on the same edge as the DUT.
    task automatic tick();
        @(posedge clk);
        if (rst)         ph = 0;
        else if (!stall) ph = (ph + 1) % 3;
        #2;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] p);
        ir = i; rs1_val = r1; rs2_val = r2; pc = p;
        #1;
    endtask

    function automatic logic [31:0] arith(input logic [2:0] fn, input logic alt,
                                          input logic [31:0] x, input logic [31:0] y);
        case (fn)
            3'd0:    return alt ? x - y : x + y;
            3'd1:    return x << y[4:0];
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    // Full comparison of every output against the ISA-level expectation.
    task automatic check_all(input string tag);
        logic [6:0]  op;
        logic [2:0]  fn;
        logic [31:0] iimm, simm, bimm, uimm, jimm, e_imm, e_res;
        logic        e_a, e_b, a_known, res_known, e_re, e_we, e_pcl, e_br, e_taken;
        logic [1:0]  e_dest;
        logic        in_fetch, in_exec, in_wb;
        state_t      e_state;
        op   = ir[6:0];
        fn   = ir[14:12];
        iimm = {{20{ir[31]}}, ir[31:20]};
        simm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
        bimm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
        uimm = {ir[31:12], 12'b0};
        jimm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
        e_imm = 0; e_res = 0; e_a = 0; e_b = 0; a_known = 1; res_known = 1;
        e_re = 0; e_we = 0; e_pcl = 0; e_br = 0; e_taken = 0; e_dest = 0;
        case (op)
            7'b0110111: begin e_imm = uimm; e_b = 1; e_dest = 1; e_res = uimm; a_known = 0; end
            7'b0010111: begin e_imm = uimm; e_a = 1; e_b = 1; e_dest = 1; e_res = pc + uimm; end
            7'b1101111: begin e_imm = jimm; e_a = 1; e_b = 1; e_dest = 3; e_pcl = 1; e_res = pc + jimm; end
            7'b1100111: begin e_imm = iimm; e_b = 1; e_dest = 3; e_pcl = 1; e_res = (rs1_val + iimm) & ~32'd1; end
            7'b1100011: begin
                e_imm = bimm;
                if (fn[2:1] == 2'b01) res_known = 0;
                else begin
                    e_br = 1;
                    if (fn[2:1] == 2'b00)      e_res = (rs1_val == rs2_val) ? 1 : 0;
                    else if (fn[2:1] == 2'b10) e_res = ($signed(rs1_val) < $signed(rs2_val)) ? 1 : 0;
                    else                       e_res = (rs1_val < rs2_val) ? 1 : 0;
                    e_taken = (e_res != 0) ^ fn[0];
                end
            end
            7'b0000011: begin e_imm = iimm; e_b = 1; e_dest = 2; e_re = 1; e_res = rs1_val + iimm; end
            7'b0100011: begin e_imm = simm; e_b = 1; e_we = 1; e_res = rs1_val + simm; end
            7'b0010011: begin e_imm = iimm; e_b = 1; e_dest = 1; e_res = arith(fn, fn == 3'd5 && ir[30], rs1_val, iimm); end
            7'b0110011: begin e_dest = 1; e_res = arith(fn, ir[30], rs1_val, rs2_val); end
            default: res_known = 0;
        endcase
        e_state  = (ph == 0) ? FETCH : (ph == 1) ? EXECUTE : WRITEBACK;
        in_fetch = !rst && ph == 0;
        in_exec  = !rst && ph == 1;
        in_wb    = !rst && ph == 2;
        chk({tag, ".state"}, {30'b0, state}, {30'b0, e_state});
        chk({tag, ".fields"}, {rd_sel, rs1_sel, rs2_sel, f3, opcode, 7'b0},
            {ir[11:7], ir[19:15], ir[24:20], ir[14:12], ir[6:0], 7'b0});
        chk({tag, ".f7"}, {25'b0, f7}, {25'b0, ir[31:25]});
        chk({tag, ".len"}, len, 32'd4);
        chk({tag, ".imm"}, imm, e_imm);
        if (a_known) chk({tag, ".in_a"}, {31'b0, alu_in_a}, {31'b0, e_a});
        chk({tag, ".in_b"}, {31'b0, alu_in_b}, {31'b0, e_b});
        chk({tag, ".dest"}, {30'b0, dest_reg_from}, {30'b0, e_dest});
        if (res_known) begin
            exp_q.push_back(e_res);
            chk({tag, ".alu_out"}, alu_out, exp_q.pop_front());
        end
        chk({tag, ".taken"}, {31'b0, branch_taken}, {31'b0, e_br & e_taken});
        chk({tag, ".strobes"},
            {24'b0, load_ir, en_iaddr, dbus_re, dbus_we, write_back_stage, en_pc_counter, pc_load, rd_we},
            {24'b0, in_fetch, in_fetch, in_exec & e_re, in_exec & e_we, in_wb, in_wb,
             in_wb & e_pcl, in_wb & (e_dest != 0)});
    endtask

    initial begin
        logic [6:0]  opc_tab[13];
        logic [31:0] r;
        opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                    7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0010011,
                    7'b0110011, 7'b0001111, 7'b1110011};

        rst = 1'b1; stall = 1'b0;
        drive(32'h0050_0093, 0, 0, 0);
        tick();
        tick();
        check_all("rst_hold");
        rst = 1'b0;
        #1;

        // addi x1,x0,5 through all three states
        drive(32'h0050_0093, 0, 0, 32'h40);
        check_all("addi_f");
        chk("addi_rd", {27'b0, rd_sel}, 32'd1);
        chk("addi_imm", imm, 32'd5);
        chk("addi_alu", alu_out, 32'd5);
        chk("addi_dest", {30'b0, dest_reg_from}, 32'd1);
        chk("addi_rdwe_f", {31'b0, rd_we}, 32'd0);
        tick(); check_all("addi_e");
        chk("addi_rdwe_e", {31'b0, rd_we}, 32'd0);
        tick(); check_all("addi_w");
        chk("addi_rdwe_w", {31'b0, rd_we}, 32'd1);
        tick();

        // sub
        drive(32'h4020_8133, 7, 9, 0);
        check_all("sub");
        chk("sub_alu", alu_out, 32'hFFFF_FFFE);

        // beq x1,x2,-4
        drive(32'hFE20_8EE3, 3, 3, 32'h100);
        check_all("beq_eq");
        chk("beq_imm", imm, 32'hFFFF_FFFC);
        chk("beq_taken", {31'b0, branch_taken}, 32'd1);
        drive(32'hFE20_8EE3, 3, 4, 32'h100);
        check_all("beq_ne");
        chk("beq_not", {31'b0, branch_taken}, 32'd0);

        // sw x2,8(x1): write strobe only in EXECUTE
        drive(32'h0020_A423, 32'h100, 32'h55, 0);
        chk("sw_alu", alu_out, 32'h108);
        chk("sw_we_f", {30'b0, dbus_we, rd_we}, 32'd0);
        tick(); check_all("sw_e");
        chk("sw_we_e", {30'b0, dbus_we, rd_we}, 32'd2);
        tick(); check_all("sw_w");
        chk("sw_we_w", {30'b0, dbus_we, rd_we}, 32'd0);
        tick();

        // stall holds EXECUTE, then reset aborts EXECUTE
        drive(32'h0000_2083, 32'h20, 0, 0);
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_all("stall_hold");
            chk("stall_state", {30'b0, state}, {30'b0, EXECUTE});
        end
        stall = 1'b0;
        tick();
        chk("stall_release", {30'b0, state}, {30'b0, WRITEBACK});
        tick(); tick();
        chk("pre_rst", {30'b0, state}, {30'b0, EXECUTE});
        rst = 1'b1; stall = 1'b1;
        #1; check_all("rst_in_exec");
        tick();
        rst = 1'b0; stall = 1'b0;
        #1; check_all("after_rst");
        chk("rst_abort", {30'b0, state}, {30'b0, FETCH});

        // randomized instructions, operands, stalls and rare resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0 || n == 0) begin
                r = $urandom;
                r[6:0] = opc_tab[$urandom_range(0, 12)];
                drive(r, $urandom, ($urandom_range(0, 3) == 0) ? rs1_val : $urandom, $urandom);
            end
            stall = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 30) == 0);
            #1;
            check_all("rand");
            tick();
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
